// File: rtl/multi_block_counter_pkg.sv
// Shared types and constants for the multi-channel block counter.
package multi_block_counter_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} blk_state_t;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_STOP = 1'b1;

endpackage

// File: rtl/multi_block_counter_if.sv
// Control/status bundle between the capture front end and block-processing logic.
interface multi_block_counter_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 10
);
    logic                      clear;
    logic                      mode;
    logic [WIDTH-1:0]          block_size;
    logic [NUM_CH-1:0]         cnt_up;
    logic [NUM_CH-1:0]         done_ack;
    logic [NUM_CH*WIDTH-1:0]   count_out;
    logic [NUM_CH-1:0]         block_done;
    logic [NUM_CH-1:0]         block_pulse;
    logic [NUM_CH-1:0]         overrun;

    modport master (
        output clear, mode, block_size, cnt_up, done_ack,
        input  count_out, block_done, block_pulse, overrun
    );

    modport slave (
        input  clear, mode, block_size, cnt_up, done_ack,
        output count_out, block_done, block_pulse, overrun
    );
endinterface

// File: rtl/multi_block_counter_channel.sv
// One counting channel: IDLE/RUN/HOLD FSM, counter, latched limit and sticky overrun.
module block_cnt_channel
    import multi_block_counter_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             clear,
    input  logic             mode,
    input  logic [WIDTH-1:0] eff,
    input  logic             cnt_up,
    input  logic             done_ack,
    output logic [WIDTH-1:0] count,
    output logic             block_done,
    output logic             block_pulse,
    output logic             overrun
);
    blk_state_t       state, state_n;
    logic [WIDTH-1:0] limit, limit_n, count_n;
    logic             done_n, pulse_n, ovr_n, take;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            count       <= '0;
            limit       <= '0;
            block_done  <= 1'b0;
            block_pulse <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            limit       <= limit_n;
            block_done  <= done_n;
            block_pulse <= pulse_n;
            overrun     <= ovr_n;
        end
    end

    // take: this edge accepts a sample into a block; completion is resolved once below
    always_comb begin
        state_n = state;
        count_n = count;
        limit_n = limit;
        done_n  = block_done;
        ovr_n   = overrun;
        pulse_n = 1'b0;
        take    = 1'b0;
        if (clear) begin
            state_n = IDLE;
            count_n = '0;
            done_n  = 1'b0;
            ovr_n   = 1'b0;
        end else begin
            case (state)
                IDLE: if (cnt_up) begin
                    take    = 1'b1;
                    count_n = WIDTH'(1);
                    limit_n = eff;
                end
                RUN: if (cnt_up) begin
                    take = 1'b1;
                    if (block_done) begin
                        count_n = WIDTH'(1);
                        limit_n = eff;
                        done_n  = 1'b0;
                    end else begin
                        count_n = count + WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (done_ack) begin
                        state_n = IDLE;
                        count_n = '0;
                        done_n  = 1'b0;
                        if (cnt_up) begin
                            take    = 1'b1;
                            count_n = WIDTH'(1);
                            limit_n = eff;
                        end
                    end else if (cnt_up) begin
                        ovr_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
            if (take) begin
                if (count_n == limit_n) begin
                    pulse_n = 1'b1;
                    done_n  = 1'b1;
                    state_n = (mode == MODE_STOP) ? HOLD : RUN;
                end else begin
                    state_n = RUN;
                end
            end
        end
    end
endmodule

// File: rtl/multi_block_counter.sv
// Top level: resolves the effective block size and fans out to NUM_CH channels.
module multi_block_counter
    import multi_block_counter_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int WIDTH        = 10,
    parameter int DEFAULT_SIZE = 1000,
    parameter bit USE_DEFAULT  = 1'b1
) (
    input  logic                  clk,
    input  logic                  n_reset,
    multi_block_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] ZERO_SIZE = USE_DEFAULT ? WIDTH'(DEFAULT_SIZE) : WIDTH'(1);

    logic [WIDTH-1:0] eff;
    assign eff = (bus.block_size == '0) ? ZERO_SIZE : bus.block_size;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        block_cnt_channel #(.WIDTH(WIDTH)) u_ch (
            .clk         (clk),
            .n_reset     (n_reset),
            .clear       (bus.clear),
            .mode        (bus.mode),
            .eff         (eff),
            .cnt_up      (bus.cnt_up[i]),
            .done_ack    (bus.done_ack[i]),
            .count       (bus.count_out[i*WIDTH +: WIDTH]),
            .block_done  (bus.block_done[i]),
            .block_pulse (bus.block_pulse[i]),
            .overrun     (bus.overrun[i])
        );
    end
endmodule

// File: doc/multi_block_counter.md
Name: multi_block_counter

Overview:
- Parametrised, multi-channel successor to the single-channel 1000-sample counter.
- Counts per-channel sample strobes into blocks of a run-time programmable size.
- Signals block completion with a one-cycle pulse and a level flag.
- Supports two modes:
  - wrap: continuous, auto-rearm.
  - stop: holds on completion until acknowledged, with sticky overrun detection for samples arriving while held.
- Sits between the sample-capture front end and the block-processing/DMA logic.

Parameters:
- NUM_CH, 4: number of independent counting channels.
- WIDTH, 10: counter and block-size width in bits.
- DEFAULT_SIZE, 1000: block size used while block_size input is 0 and USE_DEFAULT=1.
- USE_DEFAULT, 1: 1 = block_size 0 maps to DEFAULT_SIZE; 0 = block_size 0 maps to 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- n_reset  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of all channels (state, counts, flags, overrun).
- mode  in  1  0 = wrap, 1 = stop; sampled per channel at block completion.
- block_size  in  WIDTH  requested block length; latched per channel at block start.
- cnt_up  in  NUM_CH  per-channel sample strobe, one count per cycle high.
- done_ack  in  NUM_CH  per-channel acknowledge of a held block (stop mode).
- count_out  out  NUM_CH*WIDTH  per-channel current count; channel i at [i*WIDTH +: WIDTH].
- block_done  out  NUM_CH  level: channel has completed its current block.
- block_pulse  out  NUM_CH  one-cycle pulse on the cycle count reaches the limit.
- overrun  out  NUM_CH  sticky: cnt_up arrived while the channel was held.

Behaviour:
- Reset (n_reset low, asynchronous):
  - All channels go to IDLE.
  - count_out=0, block_done=0, block_pulse=0, overrun=0.
  - Latched limits go to 0.
- Effective size:
  - eff = block_size when nonzero.
  - eff = DEFAULT_SIZE or 1 when block_size is 0, per USE_DEFAULT.
- Per-channel FSM, states IDLE, RUN, HOLD. All outputs are registered and reflect state after the edge.
- IDLE (count 0):
  - cnt_up: limit <= eff, count <= 1.
  - If eff==1, complete on this edge; otherwise go to RUN.
- RUN, on cnt_up:
  - count <= count+1.
  - If count+1 == limit, complete: block_pulse=1 for exactly one cycle and block_done=1, both in the same cycle count_out first shows limit.
- Completion then depends on mode at that edge:
  - mode=0 (wrap): stay in RUN with count=limit. The next cnt_up sets count <= 1, re-latches limit <= eff, and clears block_done. If the new eff==1, that edge completes again (pulse again).
  - mode=1 (stop): go to HOLD.
- HOLD:
  - count_out holds limit and block_done stays 1.
  - cnt_up alone: sample dropped, overrun <= 1.
  - done_ack: go to IDLE, count 0, block_done 0.
  - done_ack and cnt_up in the same cycle: ack wins and the sample counts as the first of a new block (count=1, limit re-latched, overrun unchanged).
- done_ack outside HOLD is ignored.
- cnt_up without a completion never produces block_pulse.
- Latency: one clock from cnt_up to count_out, block_pulse and block_done update.
- block_size changes mid-block do not affect the running block (the latched limit is used).
- clear:
  - Highest priority after reset; overrides cnt_up and done_ack in the same cycle.
  - All channels go to IDLE, counts 0, overrun 0, block_done 0.
- Wrap of the counter register itself cannot occur: limit <= 2^WIDTH-1, so count never exceeds limit.
- Channels are fully independent; simultaneous completions on several channels pulse together.
- Reset asserted mid-block or in HOLD: immediate return to reset values; no pulse on release.

Decomposition:
- Package multi_block_counter_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, HOLD} blk_state_t.
  - localparams MODE_WRAP=1'b0, MODE_STOP=1'b1.
- Sub-module block_cnt_channel:
  - One channel: FSM, WIDTH counter, limit register, overrun flag.
  - Instantiated NUM_CH times via generate.
- The top level only computes eff and slices buses.

Test Plan:
- Reset then default size: block_size=0, mode=0, cnt_up[0] held 1000 cycles -> block_pulse[0] high exactly on cycle 1000 with count_out ch0=1000. Cycle 1001 -> count 1, block_done 0, pulse 0.
- Stop mode with overrun: block_size=5, mode=1, 7 strobes on ch1 -> pulse at 5th, count stays 5, overrun[1]=1 after 6th. done_ack -> count 0, block_done 0, overrun still 1 until clear.
- Ack and strobe collide: ch2 in HOLD at size 3, done_ack[2] and cnt_up[2] in the same cycle -> count 1, block_done 0, overrun 0.
- Size change mid-block: block_size=4, 2 strobes, then block_size=8 -> completes at 4. Next block (wrap) completes at 8.
- Size 1 wrap and clear priority: block_size=1, mode=0, cnt_up[3] continuous -> block_pulse[3] high every cycle, count 1. Assert clear with cnt_up -> count 0, all flags 0 the next cycle.
- Async reset mid-operation: n_reset low between edges with ch0 at count 7 -> outputs zero immediately, no pulse after release. Four channels counting concurrently at different rates complete independently.
